// File: rtl/bayer_mosaic_gen.sv
// Converts a 24-bit RGB stream into an 8-bit Bayer raw stream, with a fixed 2-cycle latency and no backpressure.
// Optional per-frame geometry statistics are built when FRAME_STATS_EN is defined.
module bayer_mosaic_gen #(
  parameter int unsigned BAYER_PATTERN = 0,
  parameter logic        VSYNC_POL     = 1'b1
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  logic        in_line_start,
  input  logic [23:0] in_pixel,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic        out_line_start,
  output logic [7:0]  out_raw,
  output logic [15:0] frame_count,
  output logic [13:0] stat_lines,
  output logic [13:0] stat_pixels,
  output logic        stat_valid
);

  localparam logic [1:0] PHASE = 2'(BAYER_PATTERN);

  logic        w_vs_act;
  logic        w_vs_edge;
  logic        w_den_fall;
  logic [1:0]  w_sel;
  logic [7:0]  w_raw;

  logic        r_vs_act;
  logic        r_den_d;
  logic        r_x_par;
  logic        r_y_par;
  logic [15:0] r_frame_count;

  logic        r_s1_vsync;
  logic        r_s1_hsync;
  logic        r_s1_den;
  logic        r_s1_line_start;
  logic [23:0] r_s1_pixel;
  logic [1:0]  r_s1_sel;

  logic        r_s2_vsync;
  logic        r_s2_hsync;
  logic        r_s2_den;
  logic        r_s2_line_start;
  logic [7:0]  r_s2_raw;

  assign w_vs_act   = in_vsync ~^ VSYNC_POL;
  assign w_vs_edge  = w_vs_act & ~r_vs_act;
  assign w_den_fall = r_den_d & ~in_den;
  assign w_sel      = {r_y_par ^ PHASE[1], r_x_par ^ PHASE[0]};

  // Parity state describes the pixel currently on the input, before this edge updates it.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_vs_act      <= 1'b0;
      r_den_d       <= 1'b0;
      r_x_par       <= 1'b0;
      r_y_par       <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_vs_act <= w_vs_act;
      r_den_d  <= in_den;
      r_x_par  <= in_den & ~r_x_par;
      if (w_vs_edge) begin
        r_y_par <= 1'b0;
      end else if (w_den_fall) begin
        r_y_par <= ~r_y_par;
      end
      if (w_vs_edge) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_raw = 8'h00;
    case (r_s1_sel)
      2'b00:   w_raw = r_s1_pixel[23:16];
      2'b11:   w_raw = r_s1_pixel[7:0];
      default: w_raw = r_s1_pixel[15:8];
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_s1_vsync      <= 1'b0;
      r_s1_hsync      <= 1'b0;
      r_s1_den        <= 1'b0;
      r_s1_line_start <= 1'b0;
      r_s1_pixel      <= 24'd0;
      r_s1_sel        <= 2'b00;
      r_s2_vsync      <= 1'b0;
      r_s2_hsync      <= 1'b0;
      r_s2_den        <= 1'b0;
      r_s2_line_start <= 1'b0;
      r_s2_raw        <= 8'h00;
    end else begin
      r_s1_vsync      <= in_vsync;
      r_s1_hsync      <= in_hsync;
      r_s1_den        <= in_den;
      r_s1_line_start <= in_line_start;
      r_s1_pixel      <= in_pixel;
      r_s1_sel        <= w_sel;
      r_s2_vsync      <= r_s1_vsync;
      r_s2_hsync      <= r_s1_hsync;
      r_s2_den        <= r_s1_den;
      r_s2_line_start <= r_s1_line_start;
      r_s2_raw        <= r_s1_den ? w_raw : 8'h00;
    end
  end

  assign out_vsync      = r_s2_vsync;
  assign out_hsync      = r_s2_hsync;
  assign out_den        = r_s2_den;
  assign out_line_start = r_s2_line_start;
  assign out_raw        = r_s2_raw;
  assign frame_count    = r_frame_count;

`ifdef FRAME_STATS_EN
  localparam logic [13:0] STAT_MAX = 14'h3FFF;

  logic        w_den_rise;
  logic [13:0] w_line_next;
  logic [13:0] r_pix_cnt;
  logic [13:0] r_line_cnt;
  logic [13:0] r_last_pix;
  logic [13:0] r_stat_lines;
  logic [13:0] r_stat_pixels;
  logic        r_stat_valid;

  assign w_den_rise  = in_den & ~r_den_d;
  assign w_line_next = (r_line_cnt == STAT_MAX) ? STAT_MAX : r_line_cnt + 14'd1;

  // A line ending in the vsync edge cycle still belongs to the frame being reported.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_pix_cnt     <= 14'd0;
      r_line_cnt    <= 14'd0;
      r_last_pix    <= 14'd0;
      r_stat_lines  <= 14'd0;
      r_stat_pixels <= 14'd0;
      r_stat_valid  <= 1'b0;
    end else begin
      if (w_den_rise) begin
        r_pix_cnt <= 14'd1;
      end else if (in_den && r_pix_cnt != STAT_MAX) begin
        r_pix_cnt <= r_pix_cnt + 14'd1;
      end
      if (w_den_fall) begin
        r_last_pix <= r_pix_cnt;
      end
      r_stat_valid <= w_vs_edge;
      if (w_vs_edge) begin
        r_stat_lines  <= w_den_fall ? w_line_next : r_line_cnt;
        r_stat_pixels <= w_den_fall ? r_pix_cnt : r_last_pix;
        r_line_cnt    <= 14'd0;
      end else if (w_den_fall) begin
        r_line_cnt <= w_line_next;
      end
    end
  end

  assign stat_lines  = r_stat_lines;
  assign stat_pixels = r_stat_pixels;
  assign stat_valid  = r_stat_valid;
`else
  assign stat_lines  = 14'd0;
  assign stat_pixels = 14'd0;
  assign stat_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bayer_mosaic_gen.sv
// Bench for bayer_mosaic_gen: RGGB and BGGR (inverted vsync polarity) instances driven by one stimulus stream.
// Expected values come from a run-length/line-count model of the mosaic rules plus fixed vector tables.
module tb_bayer_mosaic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, hs, den, ls;
  logic [23:0] pix;
  logic        vs_n;

  logic        o0_vs, o0_hs, o0_den, o0_ls, o0_sv;
  logic [7:0]  o0_raw;
  logic [15:0] o0_fc;
  logic [13:0] o0_sl, o0_sp;
  logic        o3_vs, o3_hs, o3_den, o3_ls, o3_sv;
  logic [7:0]  o3_raw;
  logic [15:0] o3_fc;
  logic [13:0] o3_sl, o3_sp;

  always #5 clk = ~clk;
  assign vs_n = ~vs;

  bayer_mosaic_gen #(.BAYER_PATTERN(0), .VSYNC_POL(1'b1)) dut0 (
    .pixel_clock(clk), .reset(rst), .in_vsync(vs), .in_hsync(hs), .in_den(den),
    .in_line_start(ls), .in_pixel(pix), .out_vsync(o0_vs), .out_hsync(o0_hs),
    .out_den(o0_den), .out_line_start(o0_ls), .out_raw(o0_raw), .frame_count(o0_fc),
    .stat_lines(o0_sl), .stat_pixels(o0_sp), .stat_valid(o0_sv));

  bayer_mosaic_gen #(.BAYER_PATTERN(3), .VSYNC_POL(1'b0)) dut3 (
    .pixel_clock(clk), .reset(rst), .in_vsync(vs_n), .in_hsync(hs), .in_den(den),
    .in_line_start(ls), .in_pixel(pix), .out_vsync(o3_vs), .out_hsync(o3_hs),
    .out_den(o3_den), .out_line_start(o3_ls), .out_raw(o3_raw), .frame_count(o3_fc),
    .stat_lines(o3_sl), .stat_pixels(o3_sp), .stat_valid(o3_sv));

  typedef struct {
    logic       vs0;
    logic       vs3;
    logic       hs;
    logic       den;
    logic       ls;
    logic [7:0] raw0;
    logic [7:0] raw3;
  } exp_t;

  typedef struct {
    logic       vs;
    logic       den;
    logic [7:0] e0;
    logic [7:0] e3;
  } vec_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned m_run, m_lines, m_last_pix;
  logic        m_prev_vs, m_prev_den;
  logic [15:0] m_fc;
  logic [13:0] m_sl, m_sp;
  logic        m_sv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Channel from pixel position within the line (x) and line index within the frame (y).
  function automatic logic [7:0] pick(input logic [23:0] p, input int unsigned x,
                                      input int unsigned y, input logic [1:0] ph);
    logic row_odd, col_odd;
    row_odd = ((y % 2) == 1) ^ ph[1];
    col_odd = ((x % 2) == 1) ^ ph[0];
    if (!row_odd && !col_odd) return p[23:16];
    if (row_odd && col_odd)   return p[7:0];
    return p[15:8];
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    m_run = 0; m_lines = 0; m_last_pix = 0;
    m_prev_vs = 1'b0; m_prev_den = 1'b0;
    m_fc = 16'd0; m_sl = 14'd0; m_sp = 14'd0; m_sv = 1'b0;
    q.delete();
    q.push_back(z);
  endtask

  task automatic tick(input logic v, input logic h, input logic d, input logic l, input logic [23:0] p);
    exp_t e;
    logic vedge, fall;
    vs = v; hs = h; den = d; ls = l; pix = p;
    vedge = v && !m_prev_vs;
    fall  = m_prev_den && !d;
    e.vs0 = v; e.vs3 = ~v; e.hs = h; e.den = d; e.ls = l;
    e.raw0 = d ? pick(p, m_run, m_lines, 2'd0) : 8'h00;
    e.raw3 = d ? pick(p, m_run, m_lines, 2'd3) : 8'h00;
    q.push_back(e);
    m_sv = vedge;
    if (vedge) begin
      m_fc = m_fc + 16'd1;
      m_sl = 14'(m_lines + (fall ? 1 : 0));
      m_sp = fall ? 14'(m_run) : 14'(m_last_pix);
    end
    if (fall) m_last_pix = m_run;
    if (vedge) m_lines = 0;
    else if (fall) m_lines++;
    m_run = d ? m_run + 1 : 0;
    m_prev_vs = v; m_prev_den = d;
    @(posedge clk); #1;
    e = q.pop_front();
    chk("vsync0", 32'(o0_vs), 32'(e.vs0));
    chk("vsync3", 32'(o3_vs), 32'(e.vs3));
    chk("hsync", 32'(o0_hs), 32'(e.hs));
    chk("den", 32'(o0_den), 32'(e.den));
    chk("line_start", 32'(o0_ls), 32'(e.ls));
    chk("raw_rggb", 32'(o0_raw), 32'(e.raw0));
    chk("raw_bggr", 32'(o3_raw), 32'(e.raw3));
    chk("frame_count0", 32'(o0_fc), 32'(m_fc));
    chk("frame_count3", 32'(o3_fc), 32'(m_fc));
`ifdef FRAME_STATS_EN
    chk("stat_valid", 32'(o0_sv), 32'(m_sv));
    chk("stat_lines", 32'(o0_sl), 32'(m_sl));
    chk("stat_pixels", 32'(o0_sp), 32'(m_sp));
`else
    chk("stat_valid_tied", 32'(o0_sv), 32'd0);
    chk("stat_lines_tied", 32'(o0_sl), 32'd0);
    chk("stat_pixels_tied", 32'(o0_sp), 32'd0);
`endif
  endtask

  task automatic frame(input int w, input int h, input logic rnd);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    for (int y = 0; y < h; y++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int x = 0; x < w; x++)
        tick(1'b0, 1'b0, 1'b1, (x == 0), rnd ? 24'($urandom) : 24'h112233);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vsync0"}, 32'(o0_vs), 32'd0);
    chk({tag, "_vsync3"}, 32'(o3_vs), 32'd0);
    chk({tag, "_hsync"}, 32'(o0_hs), 32'd0);
    chk({tag, "_den"}, 32'(o0_den), 32'd0);
    chk({tag, "_line_start"}, 32'(o0_ls), 32'd0);
    chk({tag, "_raw0"}, 32'(o0_raw), 32'd0);
    chk({tag, "_raw3"}, 32'(o3_raw), 32'd0);
    chk({tag, "_frame_count"}, 32'(o0_fc), 32'd0);
    chk({tag, "_stat_valid"}, 32'(o0_sv), 32'd0);
    chk({tag, "_stat_lines"}, 32'(o0_sl), 32'd0);
    chk({tag, "_stat_pixels"}, 32'(o0_sp), 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    logic lv, ld;
    // Row i's expected raw is the output seen after row i's clock: the sample of row i-1.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 8'h11, 8'h33};
    tbl[4]  = '{1'b0, 1'b1, 8'h22, 8'h22};
    tbl[5]  = '{1'b0, 1'b1, 8'h11, 8'h33};
    tbl[6]  = '{1'b0, 1'b0, 8'h22, 8'h22};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h22, 8'h22};
    tbl[10] = '{1'b0, 1'b1, 8'h33, 8'h11};
    tbl[11] = '{1'b0, 1'b0, 8'h22, 8'h22};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00};

    rst = 1'b1; vs = 1'b0; hs = 1'b0; den = 1'b0; ls = 1'b0; pix = 24'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].vs, 1'b0, tbl[i].den, 1'b0, 24'h112233);
      chk("tbl_raw_rggb", 32'(o0_raw), 32'(tbl[i].e0));
      chk("tbl_raw_bggr", 32'(o3_raw), 32'(tbl[i].e3));
    end

    // Idle: den low with all-ones pixels, syncs wiggling.
    for (int i = 0; i < 24; i++) begin
      tick(1'(i / 6 == 1), 1'(i % 3 == 0), 1'b0, 1'b0, 24'hFFFFFF);
      chk("idle_raw_zero", 32'(o0_raw), 32'd0);
    end

    // Reset in the middle of an active line.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 24'h445566);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h445566);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h445566);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midline_reset");
    den = 1'b0; ls = 1'b0; pix = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 24'h112233);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h112233);
    chk("after_reset_first_R", 32'(o0_raw), 32'h11);
    chk("after_reset_fc", 32'(o0_fc), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    for (int f = 0; f < 3; f++) frame(8, 4, 1'b0);
    chk("three_frames_fc", 32'(o0_fc), 32'd3);

    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
`ifdef FRAME_STATS_EN
    chk("frame_stat_valid_hi", 32'(o0_sv), 32'd1);
    chk("frame_stat_lines", 32'(o0_sl), 32'd4);
    chk("frame_stat_pixels", 32'(o0_sp), 32'd8);
`endif
    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    chk("frame_stat_valid_lo", 32'(o0_sv), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    // Wrap of the frame counter from a preloaded value.
    force dut0.r_frame_count = 16'hFFFF;
    force dut3.r_frame_count = 16'hFFFF;
    #1;
    release dut0.r_frame_count;
    release dut3.r_frame_count;
    m_fc = 16'hFFFF;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    chk("fc_wrap", 32'(o0_fc), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    // Vsync edge coinciding with the end of a line: next line restarts at y = 0.
    tick(1'b0, 1'b0, 1'b1, 1'b1, 24'h112233);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h112233);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 24'h112233);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h112233);
    chk("vs_and_fall_y0", 32'(o0_raw), 32'h11);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    frame(6, 3, 1'b1);

    // Continuous den without blanking.
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom));

    // Random sync/den activity.
    lv = 1'b0; ld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) lv = ~lv;
      if ($urandom_range(0, 5) == 0) ld = ~ld;
      tick(lv, 1'($urandom_range(0, 1)), ld, ld && !m_prev_den, 24'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bayer_mosaic_gen.md
# bayer_mosaic_gen

Converts the 24-bit RGB test-pattern stream into an 8-bit Bayer raw stream, so the ISP demosaic path can be exercised without a sensor. It sits directly downstream of the test pattern generator and upstream of the raw-input ISP stages. It tracks pixel and line parity from the incoming sync and enable signals. All sync signals are delayed to stay aligned with the selected raw sample. It also keeps a frame counter and, optionally, per-frame geometry statistics.

## Interface
- BAYER_PATTERN, 0: CFA phase. 0 = RGGB, 1 = GRBG, 2 = GBRG, 3 = BGGR.
- VSYNC_POL, 1: active level of in_vsync.
- pixel_clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_vsync, in_hsync, in_den, in_line_start  in  1 each  upstream timing signals.
- in_pixel  in  24  RGB pixel: R[23:16], G[15:8], B[7:0].
- out_vsync, out_hsync, out_den, out_line_start  out  1 each  timing signals delayed by 2 cycles.
- out_raw  out  8  Bayer sample; 0 when out_den is low.
- frame_count  out  16  count of vsync active edges since reset; wraps.
- stat_lines  out  14  active lines in the last frame (FRAME_STATS_EN only).
- stat_pixels  out  14  active pixels in the last line of the last frame (FRAME_STATS_EN only).
- stat_valid  out  1  one-cycle pulse when the stat_* outputs update (FRAME_STATS_EN only).

## Operation
- Vsync edge: vs_act = in_vsync ~^ VSYNC_POL. A vsync edge is vs_act rising (registered vs_act was 0, now 1).
- x_par: cleared while in_den = 0; toggles on every cycle with in_den = 1. The first pixel of each line therefore has x = 0.
- y_par:
  - cleared on a vsync edge;
  - otherwise toggles on every in_den falling edge (end of line).
  - If a vsync edge and a den falling edge occur in the same cycle, the vsync edge wins and y_par becomes 0.
- Phase: {py, px} = BAYER_PATTERN[1:0]; sel = {y_par ^ py, x_par ^ px}.
- Channel select by sel: 00 → R, 01 → G, 10 → G, 11 → B. No arithmetic; the selected byte passes unmodified.
- Pipeline:
  - Stage 1 registers in_pixel, the timing signals and sel.
  - Stage 2 registers out_raw (muxed, forced to 0 when the stage-1 den is 0) and the delayed timing signals.
- frame_count: increments on each vsync edge, wraps 0xFFFF → 0.
- Reset mid-frame: all state clears immediately. Parity resumes from x = 0, y = 0 at the next active line. Output stays consistent from the next vsync onward.

## Timing
- Latency: exactly 2 cycles, from every input to every corresponding output.
- Reset values: every output 0, all internal registers 0. frame_count = 0.
- There is no backpressure; the block accepts one pixel per cycle unconditionally.
- The first frame_count increment is visible on frame_count 1 cycle after the vsync edge cycle.
- Continuous den (no blanking) is legal: x_par keeps toggling and y_par never changes.

## Configuration
- FRAME_STATS_EN defined:
  - A 14-bit pixel counter counts den cycles per line and clears at den rise.
  - A 14-bit line counter counts den falls per frame. Both counters saturate at 0x3FFF.
  - On a vsync edge, the line count (including a line ending in the same cycle) is latched to stat_lines and the last completed line's pixel count to stat_pixels.
  - The line counter then clears, and stat_valid pulses 1 cycle after the edge.
- FRAME_STATS_EN undefined: no counters are built. stat_lines, stat_pixels and stat_valid are tied to 0.

## Test plan
- RGGB, 8x4 visible frame, constant in_pixel 0x112233 → out_raw sequence:
  - even lines: 0x11, 0x22, 0x11, 0x22, …
  - odd lines: 0x22, 0x33, …
  - each sample appears 2 cycles after its input.
- BAYER_PATTERN = 3 (BGGR), same stimulus → line 0 starts 0x33, 0x22; line 1 starts 0x22, 0x11.
- Hold in_den = 0, in_pixel = 0xFFFFFF → out_raw stays 0x00. out_hsync and out_vsync equal the inputs delayed by 2 cycles.
- Run 3 frames → frame_count = 3. Preload a force to 0xFFFF, then one more vsync edge → frame_count = 0x0000.
- Assert reset mid-line:
  - all outputs are 0 in the same cycle;
  - after release, the next line's first out_raw is R;
  - frame_count restarts at 0.
- FRAME_STATS_EN, 8x4 frame → at the next vsync edge, stat_lines = 4 and stat_pixels = 8, with stat_valid high for exactly 1 cycle.
